// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache with line-fill sequencer
module icache_ctrl #(
    parameter int INDEX_BITS        = 4,
    parameter int OFFSET_WORDS_BITS = 2,
    parameter int ADDR_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_done,
    output logic [31:0]       if_data,
    output logic              memc_en,
    output logic [ADDR_W-1:0] memc_pc,
    input  logic              memc_done,
    input  logic [31:0]       memc_data,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);
    localparam int LINE_LSB    = OFFSET_WORDS_BITS + 2;
    localparam int TAG_W       = ADDR_W - INDEX_BITS - LINE_LSB;
    localparam int LINES       = 1 << INDEX_BITS;
    localparam int WORDS_TOTAL = LINES << OFFSET_WORDS_BITS;
    localparam logic [OFFSET_WORDS_BITS-1:0] LAST_WORD = '1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]             valid_q;
    logic [TAG_W-1:0]             tag_mem  [LINES];
    logic [31:0]                  data_mem [WORDS_TOTAL];

    logic [OFFSET_WORDS_BITS-1:0] k_q, k_d;
    logic [INDEX_BITS-1:0]        fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]             fill_tag_q, fill_tag_d;

    logic                         if_done_d, memc_en_d;
    logic [31:0]                  if_data_d, hits_d, misses_d;
    logic [ADDR_W-1:0]            memc_pc_d;
    logic                         data_we, line_done, line_inval;

    logic [OFFSET_WORDS_BITS-1:0] pc_off;
    logic [INDEX_BITS-1:0]        pc_idx;
    logic [TAG_W-1:0]             pc_tag;
    logic                         hit;
    logic                         unused_pc_bits;

    assign pc_off         = if_pc[LINE_LSB-1:2];
    assign pc_idx         = if_pc[LINE_LSB +: INDEX_BITS];
    assign pc_tag         = if_pc[ADDR_W-1:LINE_LSB+INDEX_BITS];
    assign hit            = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign unused_pc_bits = ^if_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            if_done     <= 1'b0;
            if_data     <= '0;
            memc_en     <= 1'b0;
            memc_pc     <= '0;
            k_q         <= '0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            if_done     <= if_done_d;
            if_data     <= if_data_d;
            memc_en     <= memc_en_d;
            memc_pc     <= memc_pc_d;
            k_q         <= k_d;
            fill_idx_q  <= fill_idx_d;
            fill_tag_q  <= fill_tag_d;
            perf_hits   <= hits_d;
            perf_misses <= misses_d;
            if (line_inval) valid_q[pc_idx] <= 1'b0;
            if (line_done) valid_q[fill_idx_q] <= 1'b1;
        end
    end

    // Line storage carries no reset; the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (data_we) data_mem[{fill_idx_q, k_q}] <= memc_data;
            if (line_done) tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        if_done_d  = if_done;
        if_data_d  = if_data;
        memc_en_d  = memc_en;
        memc_pc_d  = memc_pc;
        k_d        = k_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        hits_d     = perf_hits;
        misses_d   = perf_misses;
        data_we    = 1'b0;
        line_done  = 1'b0;
        line_inval = 1'b0;

        if (rollback) begin
            state_d   = IDLE;
            memc_en_d = 1'b0;
            if_done_d = 1'b0;
            k_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if_done_d = 1'b0;
                    // The request is still visible while if_done is high; skip it.
                    if (if_en && !if_done) begin
                        if (hit) begin
                            if_done_d = 1'b1;
                            if_data_d = data_mem[{pc_idx, pc_off}];
                            hits_d    = perf_hits + 32'd1;
                        end else begin
                            state_d    = FILL;
                            memc_en_d  = 1'b1;
                            memc_pc_d  = {if_pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                            k_d        = '0;
                            fill_idx_d = pc_idx;
                            fill_tag_d = pc_tag;
                            misses_d   = perf_misses + 32'd1;
                            line_inval = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if_done_d = 1'b0;
                    if (memc_done) begin
                        data_we = 1'b1;
                        if (k_q == LAST_WORD) begin
                            line_done = 1'b1;
                            memc_en_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            k_d       = k_q + 1'b1;
                            memc_pc_d = memc_pc + ADDR_W'(4);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule
